wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 3, the number of consecutive cycles a queued load write may wait before the block forces a drain slot.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports pipe_wr_req / pipe_wr_reg / pipe_wr_data, input, 1/3/16: the in-order pipeline writeback request, its destination register and the selected writeback data.
REQ-005 The block SHALL have ports ld_wr_req / ld_wr_reg / ld_wr_data, input, 1/3/16: the late load-return request from the multi-cycle memory unit.
REQ-006 The block SHALL have port ld_wr_ack, output, 1, meaning the load request is accepted this cycle.
REQ-007 The block SHALL have ports rf_wr_en / rf_wr_reg / rf_wr_data, output, 1/3/16, the single register-file write port.
REQ-008 The block SHALL have port pipe_stall, output, 1, meaning the pipeline writeback is refused this cycle and the pipeline must hold its request.
REQ-009 The block SHALL have port pend_busy, output, 8, a one-hot-per-register mask of valid queued load writes, used for interlock.

Function
REQ-010 The block SHALL hold a 2-entry in-order queue of load writes, each entry being {valid, reg[2:0], data[15:0]}, with the head always being the oldest entry.
REQ-011 ld_wr_ack SHALL be combinational and equal ld_wr_req AND (queue count < 2 OR a head drain occurs this cycle).
REQ-012 Grant priority: when pipe_stall=0 and pipe_wr_req=1, the block SHALL drive the pipe write to the RF port; otherwise, when the queue is non-empty, it SHALL drive the queue head to the RF port.
REQ-013 rf_wr_en, rf_wr_reg and rf_wr_data SHALL be combinational from the current inputs and state, giving zero added latency.
REQ-014 When idle, rf_wr_en SHALL be 0, rf_wr_reg SHALL be 0 and rf_wr_data SHALL be 0.
REQ-015 The head entry SHALL be removed on the edge of the cycle in which it is granted.
REQ-016 An accepted load SHALL be enqueued at the tail on the same edge.
REQ-017 With count=2, a simultaneous drain and accept SHALL leave count at 2.
REQ-018 Bypass: a load accepted when the queue is empty and pipe_wr_req=0 SHALL NOT be written in the same cycle; it is enqueued and writes on the next free cycle, giving a fixed minimum latency of 1.
REQ-019 WAW kill: on a cycle in which a pipe write to register R is granted, every valid queued entry with reg=R SHALL be invalidated on that edge, and remaining entries SHALL compact toward the head.
REQ-020 WAW kill: an ld_wr_req to R accepted in the same cycle SHALL be acked but not enqueued.
REQ-021 The starve counter (2 bits) SHALL increment each cycle the queue is non-empty and the head is not granted.
REQ-022 The starve counter SHALL clear on a head grant or when the queue is empty.
REQ-023 The starve counter SHALL saturate at STARVE_LIMIT.
REQ-024 pipe_stall SHALL be registered and asserted for exactly one cycle after the starve counter reaches STARVE_LIMIT.
REQ-025 In the pipe_stall cycle the head SHALL be granted regardless of pipe_wr_req.
REQ-026 In the pipe_stall cycle no pipe write SHALL occur and no WAW kill SHALL occur.
REQ-027 pipe_stall SHALL NOT assert in two consecutive cycles.
REQ-028 pend_busy[r] SHALL be 1 if any valid queued entry has reg=r, reflecting registered state only.

Reset
REQ-029 Assertion of rst_n=0 SHALL asynchronously clear the queue valid bits, the count, the starve counter and pipe_stall.
REQ-030 During reset, rf_wr_en, ld_wr_ack, pipe_stall and pend_busy SHALL be 0.
REQ-031 A reset mid-queue SHALL discard pending writes without issuing them.
REQ-032 The first grant SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-033 Scenario: ld_wr_req reg=3 data=16'hBEEF with the pipe idle -> ack=1, pend_busy=8'h08; next cycle rf_wr_en=1, reg=3, data=BEEF; pend_busy=0 after that.
REQ-034 Scenario: two loads enqueued (reg 1, 2) while pipe_wr_req is held at 1 continuously -> third ld_wr_req gets ack=0; after 3 non-granted cycles pipe_stall=1 for one cycle and reg 1 is written; pipe write resumes the following cycle.
REQ-035 Scenario: queue holds reg=5 data=16'h1111; pipe writes reg=5 data=16'h2222 -> RF gets 2222 only; entry is killed; pend_busy[5]=0 next cycle; no later write to reg 5.
REQ-036 Scenario: queue full, pipe idle, new ld_wr_req -> head is drained and ack=1 in the same cycle; count stays 2 and order is preserved.
REQ-037 Scenario: rst_n pulsed low mid-cycle with 2 entries queued -> outputs are 0 immediately; after release, no RF write occurs without a new request.
REQ-038 Scenario: pipe_wr_req and ld_wr_req both to reg=4 in the same cycle, queue empty -> pipe value is written, ld_wr_ack=1, and the queue stays empty.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Single register-file write port shared between the in-order
//               pipeline writeback and late load returns. Load returns sit in
//               a 2-entry in-order queue; pipe writes have priority, a starve
//               counter forces a one-cycle pipe stall to drain the queue, and
//               pipe writes kill queued loads to the same register (WAW).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wr_req,
  input  logic [2:0]  pipe_wr_reg,
  input  logic [15:0] pipe_wr_data,
  input  logic        ld_wr_req,
  input  logic [2:0]  ld_wr_reg,
  input  logic [15:0] ld_wr_data,
  output logic        ld_wr_ack,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_reg,
  output logic [15:0] rf_wr_data,
  output logic        pipe_stall,
  output logic [7:0]  pend_busy
);

  localparam logic [1:0] C_LIMIT = 2'(STARVE_LIMIT);

  // Queue storage; entry 0 is always the head (oldest)
  logic [1:0]  r_valid;
  logic [2:0]  r_reg  [2];
  logic [15:0] r_data [2];
  logic [1:0]  r_count;
  logic [1:0]  r_starve;
  logic        r_stall;
  // Low until the first clock edge after reset release, so no grant can
  // appear in the partial cycle following deassertion
  logic        r_run;

  logic        w_pipe_grant;
  logic        w_head_grant;
  logic        w_ld_kill;
  logic        w_enq;
  logic        w_keep0;
  logic        w_keep1;
  logic [1:0]  w_nvalid;
  logic [2:0]  w_nreg  [2];
  logic [15:0] w_ndata [2];
  logic [1:0]  w_ncount;
  logic [1:0]  w_nstarve;

  assign w_pipe_grant = r_run & pipe_wr_req & ~r_stall;
  assign w_head_grant = r_run & ~w_pipe_grant & (r_count != 2'd0);
  assign ld_wr_ack    = r_run & ld_wr_req & ((r_count < 2'd2) | w_head_grant);
  // A load racing a pipe write to the same register is already stale
  assign w_ld_kill    = w_pipe_grant & (ld_wr_reg == pipe_wr_reg);
  assign w_enq        = ld_wr_ack & ~w_ld_kill;
  assign w_keep0      = r_valid[0] & ~w_head_grant &
                        ~(w_pipe_grant & (r_reg[0] == pipe_wr_reg));
  assign w_keep1      = r_valid[1] & ~(w_pipe_grant & (r_reg[1] == pipe_wr_reg));
  assign pipe_stall   = r_stall;

  // Build the next queue: surviving entries compacted toward the head, then the new load
  always_comb begin
    w_nreg[0]  = r_reg[0];
    w_nreg[1]  = r_reg[1];
    w_ndata[0] = r_data[0];
    w_ndata[1] = r_data[1];
    w_ncount   = 2'd0;
    if (w_keep0) begin
      w_ncount = 2'd1;
    end
    if (w_keep1) begin
      if (w_ncount == 2'd0) begin
        w_nreg[0]  = r_reg[1];
        w_ndata[0] = r_data[1];
      end else begin
        w_nreg[1]  = r_reg[1];
        w_ndata[1] = r_data[1];
      end
      w_ncount = w_ncount + 2'd1;
    end
    if (w_enq) begin
      if (w_ncount == 2'd0) begin
        w_nreg[0]  = ld_wr_reg;
        w_ndata[0] = ld_wr_data;
      end else begin
        w_nreg[1]  = ld_wr_reg;
        w_ndata[1] = ld_wr_data;
      end
      w_ncount = w_ncount + 2'd1;
    end
    w_nvalid = {(w_ncount == 2'd2), (w_ncount != 2'd0)};
  end

  // Starve counter: counts cycles a non-empty queue loses arbitration, saturating
  always_comb begin
    if ((r_count == 2'd0) || w_head_grant) begin
      w_nstarve = 2'd0;
    end else if (r_starve >= C_LIMIT) begin
      w_nstarve = C_LIMIT;
    end else begin
      w_nstarve = r_starve + 2'd1;
    end
  end

  // Control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 2'b00;
      r_count  <= 2'd0;
      r_starve <= 2'd0;
      r_stall  <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      r_valid  <= w_nvalid;
      r_count  <= w_ncount;
      r_starve <= w_nstarve;
      r_stall  <= (w_nstarve == C_LIMIT) & ~r_stall;
      r_run    <= 1'b1;
    end
  end

  // Entry payload; only meaningful where the matching valid bit is set
  always_ff @(posedge clk) begin
    r_reg[0]  <= w_nreg[0];
    r_reg[1]  <= w_nreg[1];
    r_data[0] <= w_ndata[0];
    r_data[1] <= w_ndata[1];
  end

  // Register-file port mux: pipe first, then queue head, else quiet zeros
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_reg  = 3'd0;
    rf_wr_data = 16'h0000;
    if (w_pipe_grant) begin
      rf_wr_en   = 1'b1;
      rf_wr_reg  = pipe_wr_reg;
      rf_wr_data = pipe_wr_data;
    end else if (w_head_grant) begin
      rf_wr_en   = 1'b1;
      rf_wr_reg  = r_reg[0];
      rf_wr_data = r_data[0];
    end
  end

  // Interlock mask of registers with a pending queued load
  always_comb begin
    pend_busy = 8'h00;
    for (int i = 0; i < 2; i++) begin
      if (r_valid[i]) begin
        pend_busy[r_reg[i]] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter: directed scenarios
//               plus randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam int STARVE_LIMIT = 3;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_wr_req = 1'b0;
  logic [2:0]  pipe_wr_reg = 3'd0;
  logic [15:0] pipe_wr_data = 16'h0;
  logic        ld_wr_req = 1'b0;
  logic [2:0]  ld_wr_reg = 3'd0;
  logic [15:0] ld_wr_data = 16'h0;
  logic        ld_wr_ack;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_reg;
  logic [15:0] rf_wr_data;
  logic        pipe_stall;
  logic [7:0]  pend_busy;

  int          n_vec = 0;
  int          n_err = 0;
  logic [29:0] e;

  wb_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_wr_req  (pipe_wr_req),
    .pipe_wr_reg  (pipe_wr_reg),
    .pipe_wr_data (pipe_wr_data),
    .ld_wr_req    (ld_wr_req),
    .ld_wr_reg    (ld_wr_reg),
    .ld_wr_data   (ld_wr_data),
    .ld_wr_ack    (ld_wr_ack),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_reg    (rf_wr_reg),
    .rf_wr_data   (rf_wr_data),
    .pipe_stall   (pipe_stall),
    .pend_busy    (pend_busy)
  );

  always #5 clk = ~clk;

  // Observed bundle: {ack, en, reg, data, stall, pend_busy}
  wire [29:0] w_obs = {ld_wr_ack, rf_wr_en, rf_wr_reg, rf_wr_data, pipe_stall, pend_busy};

  function automatic logic [29:0] pack(input logic a, input logic en, input logic [2:0] rg,
                                       input logic [15:0] d, input logic st, input logic [7:0] pb);
    return {a, en, rg, d, st, pb};
  endfunction

  task automatic drive(input logic pr, input logic [2:0] preg, input logic [15:0] pd,
                       input logic lr, input logic [2:0] lreg, input logic [15:0] ld);
    pipe_wr_req  = pr;
    pipe_wr_reg  = preg;
    pipe_wr_data = pd;
    ld_wr_req    = lr;
    ld_wr_reg    = lreg;
    ld_wr_data   = ld;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 3'd2, 16'h1234, 1'b1, 3'd2, 16'h5678);
    #3;
    e = pack(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL reset_hold: got %h want %h", w_obs, e); end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    e = pack(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL reset_release_nogrant: got %h want %h", w_obs, e); end
    next_cycle();
    @(negedge clk);
    e = pack(1'b1, 1'b1, 3'd2, 16'h1234, 1'b0, 8'h00); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL reset_first_grant: got %h want %h", w_obs, e); end
    next_cycle();
    idle();
    @(negedge clk);
    e = pack(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL reset_killed_load: got %h want %h", w_obs, e); end
  endtask

  task automatic test_bypass();
    do_reset();
    next_cycle(); drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'hBEEF); @(negedge clk);
    e = pack(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL bypass_accept: got %h want %h", w_obs, e); end
    next_cycle(); idle(); @(negedge clk);
    e = pack(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 8'h08); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL bypass_write: got %h want %h", w_obs, e); end
    next_cycle(); @(negedge clk);
    e = pack(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL bypass_empty: got %h want %h", w_obs, e); end
  endtask

  task automatic test_starve();
    logic [29:0] exp_t [8];
    exp_t[0] = pack(1'b1, 1'b1, 3'd7, 16'h0007, 1'b0, 8'h00);
    exp_t[1] = pack(1'b1, 1'b1, 3'd7, 16'h0007, 1'b0, 8'h02);
    exp_t[2] = pack(1'b0, 1'b1, 3'd7, 16'h0007, 1'b0, 8'h06);
    exp_t[3] = pack(1'b0, 1'b1, 3'd7, 16'h0007, 1'b0, 8'h06);
    exp_t[4] = pack(1'b0, 1'b1, 3'd1, 16'h00A1, 1'b1, 8'h06);
    exp_t[5] = pack(1'b0, 1'b1, 3'd7, 16'h0007, 1'b0, 8'h04);
    exp_t[6] = pack(1'b0, 1'b1, 3'd2, 16'h00A2, 1'b0, 8'h04);
    exp_t[7] = pack(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00);
    do_reset();
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      case (c)
        0:       drive(1'b1, 3'd7, 16'h0007, 1'b1, 3'd1, 16'h00A1);
        1:       drive(1'b1, 3'd7, 16'h0007, 1'b1, 3'd2, 16'h00A2);
        2, 3:    drive(1'b1, 3'd7, 16'h0007, 1'b1, 3'd3, 16'h00A3);
        4, 5:    drive(1'b1, 3'd7, 16'h0007, 1'b0, 3'd0, 16'h0);
        default: idle();
      endcase
      @(negedge clk);
      n_vec++;
      if (w_obs !== exp_t[c]) begin
        n_err++; $display("FAIL starve_c%0d: got %h want %h", c, w_obs, exp_t[c]);
      end
    end
  endtask

  task automatic test_waw_kill();
    do_reset();
    next_cycle(); drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h1111); @(negedge clk);
    e = pack(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL waw_enqueue: got %h want %h", w_obs, e); end
    next_cycle(); drive(1'b1, 3'd5, 16'h2222, 1'b0, 3'd0, 16'h0); @(negedge clk);
    e = pack(1'b0, 1'b1, 3'd5, 16'h2222, 1'b0, 8'h20); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL waw_pipe_write: got %h want %h", w_obs, e); end
    for (int c = 0; c < 2; c++) begin
      next_cycle(); idle(); @(negedge clk);
      e = pack(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00); n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL waw_no_late_write%0d: got %h want %h", c, w_obs, e); end
    end
  endtask

  task automatic test_full_drain();
    logic [29:0] exp_t [6];
    exp_t[0] = pack(1'b1, 1'b1, 3'd7, 16'h0007, 1'b0, 8'h00);
    exp_t[1] = pack(1'b1, 1'b1, 3'd7, 16'h0007, 1'b0, 8'h02);
    exp_t[2] = pack(1'b1, 1'b1, 3'd1, 16'h0101, 1'b0, 8'h06);
    exp_t[3] = pack(1'b0, 1'b1, 3'd2, 16'h0202, 1'b0, 8'h0C);
    exp_t[4] = pack(1'b0, 1'b1, 3'd3, 16'h0303, 1'b0, 8'h08);
    exp_t[5] = pack(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00);
    do_reset();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      case (c)
        0:       drive(1'b1, 3'd7, 16'h0007, 1'b1, 3'd1, 16'h0101);
        1:       drive(1'b1, 3'd7, 16'h0007, 1'b1, 3'd2, 16'h0202);
        2:       drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h0303);
        default: idle();
      endcase
      @(negedge clk);
      n_vec++;
      if (w_obs !== exp_t[c]) begin
        n_err++; $display("FAIL full_drain_c%0d: got %h want %h", c, w_obs, exp_t[c]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    next_cycle(); drive(1'b1, 3'd7, 16'h0007, 1'b1, 3'd1, 16'h0101);
    next_cycle(); drive(1'b1, 3'd7, 16'h0007, 1'b1, 3'd2, 16'h0202);
    next_cycle(); drive(1'b1, 3'd6, 16'h0006, 1'b1, 3'd3, 16'h0303);
    #1;
    e = pack(1'b0, 1'b1, 3'd6, 16'h0006, 1'b0, 8'h06); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL midrst_full: got %h want %h", w_obs, e); end
    #1; rst_n = 1'b0; #1;
    e = pack(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL midrst_async: got %h want %h", w_obs, e); end
    idle();
    #1; rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle(); @(negedge clk);
      e = pack(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00); n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL midrst_discard%0d: got %h want %h", c, w_obs, e); end
    end
  endtask

  task automatic test_same_reg();
    do_reset();
    next_cycle(); drive(1'b1, 3'd4, 16'h4444, 1'b1, 3'd4, 16'h5555); @(negedge clk);
    e = pack(1'b1, 1'b1, 3'd4, 16'h4444, 1'b0, 8'h00); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL same_reg_write: got %h want %h", w_obs, e); end
    next_cycle(); idle(); @(negedge clk);
    e = pack(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00); n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL same_reg_empty: got %h want %h", w_obs, e); end
  endtask

  // Randomized traffic vs. a reference built on an ordinary queue of pending loads
  task automatic test_random();
    ent_t        mq[$];
    ent_t        tmpq[$];
    int          m_wait;
    bit          m_stall;
    logic        pr, lr, p_ok, drn, m_ack;
    logic [2:0]  preg, lreg;
    logic [15:0] pd, ld;
    logic [7:0]  pend;
    int          sz0;
    mq.delete();
    m_wait  = 0;
    m_stall = 1'b0;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      next_cycle();
      pr   = ($urandom_range(0, 99) < (((k / 100) % 2 == 0) ? 85 : 40));
      lr   = ($urandom_range(0, 99) < 55);
      preg = 3'($urandom_range(0, 3));
      lreg = 3'($urandom_range(0, 3));
      pd   = 16'($urandom);
      ld   = 16'($urandom);
      drive(pr, preg, pd, lr, lreg, ld);
      p_ok  = pr && !m_stall;
      drn   = !p_ok && (mq.size() > 0);
      m_ack = lr && ((mq.size() < 2) || drn);
      pend  = 8'h00;
      foreach (mq[j]) pend[mq[j].r] = 1'b1;
      if (p_ok)     e = pack(m_ack, 1'b1, preg, pd, m_stall, pend);
      else if (drn) e = pack(m_ack, 1'b1, mq[0].r, mq[0].d, m_stall, pend);
      else          e = pack(m_ack, 1'b0, 3'd0, 16'h0, m_stall, pend);
      @(negedge clk);
      n_vec++;
      if (w_obs !== e) begin
        n_err++; $display("FAIL random_k%0d: got %h want %h", k, w_obs, e);
      end
      sz0 = mq.size();
      if (drn) void'(mq.pop_front());
      if (p_ok) begin
        tmpq.delete();
        foreach (mq[j]) if (mq[j].r != preg) tmpq.push_back(mq[j]);
        mq = tmpq;
      end
      if (m_ack && !(p_ok && (lreg == preg))) mq.push_back('{lreg, ld});
      if ((sz0 == 0) || drn) m_wait = 0;
      else if (m_wait < STARVE_LIMIT) m_wait++;
      m_stall = (m_wait == STARVE_LIMIT) && !m_stall;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_starve();
    test_waw_kill();
    test_full_drain();
    test_mid_reset();
    test_same_reg();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
